// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-master I2C controller.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      START,
      ADDR,
      ADDR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK,
      STOP
   } state_t;

   typedef logic [1:0] quarter_t;

   localparam quarter_t Q0 = 2'd0;
   localparam quarter_t Q1 = 2'd1;
   localparam quarter_t Q2 = 2'd2;
   localparam quarter_t Q3 = 2'd3;

   localparam logic I2C_WRITE = 1'b0;
   localparam logic I2C_READ  = 1'b1;

   // SCL is released only in the middle two quarters of a clocked bit slot.
   function automatic logic scl_release(input quarter_t q);
      return (q == Q1) || (q == Q2);
   endfunction

endpackage

// File: rtl/i2c_clk_div.sv
// Quarter-period tick generator; a hold input freezes the count while a slave stretches SCL.
module i2c_clk_div #(
   parameter int CLK_DIV = 125
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clr,
   input  logic i_hold,
   output logic o_tick
);

   localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [W-1:0] LOAD = W'(CLK_DIV - 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clr) begin
         r_cnt <= LOAD;
      end else if (!i_hold) begin
         r_cnt <= (r_cnt == '0) ? LOAD : r_cnt - 1'b1;
      end
   end

   assign o_tick = !i_clr && !i_hold && (r_cnt == '0);

endmodule

// File: rtl/i2c_master.sv
// Single-master I2C controller: one-byte write or read per transaction, open-drain SDA/SCL controls.
//
// state     | meaning
// IDLE      | lines released, waiting for I_START
// START     | SDA falls while SCL high, then SCL pulled low
// ADDR      | shift out {addr, rw}, MSB first
// ADDR_ACK  | SDA released, slave acknowledge sampled
// WDATA     | shift out write byte
// WDATA_ACK | SDA released, slave acknowledge sampled
// RDATA     | SDA released, shift in read byte
// RDATA_ACK | master releases SDA (NACK) to end the read
// STOP      | SDA rises while SCL high
module i2c_master
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 125
) (
   input  logic       I_CLK,
   input  logic       I_RESET,
   input  logic       I_START,
   input  logic       I_RW,
   input  logic [6:0] I_ADDR,
   input  logic [7:0] I_WDATA,
   input  logic       I_SDA_IN,
   input  logic       I_SCL_IN,
   output logic       O_SDA_T,
   output logic       O_SCL_T,
   output logic       O_BUSY,
   output logic       O_DONE,
   output logic       O_NACK,
   output logic [7:0] O_RDATA
);

   state_t     r_state, w_state_nxt;
   quarter_t   r_q, w_q_nxt;
   logic [2:0] r_bit, w_bit_nxt;

   logic       r_rw;
   logic [6:0] r_addr;
   logic [7:0] r_wdata;
   logic [7:0] r_shift;
   logic [7:0] r_rdata;
   logic       r_sample;
   logic       r_sda_t, r_scl_t, r_busy, r_done, r_nack;

   logic       w_tick, w_hold, w_clr, w_accept, w_end_slot;
   logic       w_sda_nxt, w_scl_nxt;
   logic [7:0] w_addr_byte;

   assign w_accept    = (r_state == IDLE) && I_START;
   assign w_end_slot  = w_tick && (r_q == Q3);
   assign w_clr       = (r_state == IDLE);
   assign w_hold      = (r_state != IDLE) && (r_q == Q1) && !I_SCL_IN;
   assign w_addr_byte = {r_addr, r_rw};

   i2c_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .i_clk   (I_CLK),
      .i_reset (I_RESET),
      .i_clr   (w_clr),
      .i_hold  (w_hold),
      .o_tick  (w_tick)
   );

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         r_state <= IDLE;
         r_q     <= Q0;
         r_bit   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_bit   <= w_bit_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_bit_nxt   = r_bit;
      if (r_state == IDLE) begin
         if (I_START) begin
            w_state_nxt = START;
            w_q_nxt     = Q0;
            w_bit_nxt   = 3'd0;
         end
      end else if (w_tick) begin
         w_q_nxt = r_q + 2'd1;
         if (r_q == Q3) begin
            case (r_state)
               START:     w_state_nxt = ADDR;
               ADDR: begin
                  w_bit_nxt = r_bit + 3'd1;
                  if (r_bit == 3'd7) w_state_nxt = ADDR_ACK;
               end
               ADDR_ACK: begin
                  if (r_sample)              w_state_nxt = STOP;
                  else if (r_rw == I2C_READ) w_state_nxt = RDATA;
                  else                       w_state_nxt = WDATA;
               end
               WDATA: begin
                  w_bit_nxt = r_bit + 3'd1;
                  if (r_bit == 3'd7) w_state_nxt = WDATA_ACK;
               end
               WDATA_ACK: w_state_nxt = STOP;
               RDATA: begin
                  w_bit_nxt = r_bit + 3'd1;
                  if (r_bit == 3'd7) w_state_nxt = RDATA_ACK;
               end
               RDATA_ACK: w_state_nxt = STOP;
               STOP:      w_state_nxt = IDLE;
               default:   w_state_nxt = IDLE;
            endcase
         end
      end
   end

   // Line levels are decoded from the next state so the registered pins line up with the quarter.
   always_comb begin
      w_sda_nxt = 1'b1;
      w_scl_nxt = 1'b1;
      case (w_state_nxt)
         START: begin
            w_sda_nxt = (w_q_nxt == Q0) || (w_q_nxt == Q1);
            w_scl_nxt = (w_q_nxt != Q3);
         end
         ADDR: begin
            w_sda_nxt = w_addr_byte[3'd7 - w_bit_nxt];
            w_scl_nxt = scl_release(w_q_nxt);
         end
         WDATA: begin
            w_sda_nxt = r_wdata[3'd7 - w_bit_nxt];
            w_scl_nxt = scl_release(w_q_nxt);
         end
         ADDR_ACK, WDATA_ACK, RDATA, RDATA_ACK: begin
            w_sda_nxt = 1'b1;
            w_scl_nxt = scl_release(w_q_nxt);
         end
         STOP: begin
            w_sda_nxt = (w_q_nxt == Q2) || (w_q_nxt == Q3);
            w_scl_nxt = (w_q_nxt != Q0);
         end
         default: begin
            w_sda_nxt = 1'b1;
            w_scl_nxt = 1'b1;
         end
      endcase
   end

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         r_rw     <= 1'b0;
         r_addr   <= 7'd0;
         r_wdata  <= 8'd0;
         r_shift  <= 8'd0;
         r_rdata  <= 8'd0;
         r_sample <= 1'b0;
         r_sda_t  <= 1'b1;
         r_scl_t  <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_nack   <= 1'b0;
      end else begin
         r_sda_t <= w_sda_nxt;
         r_scl_t <= w_scl_nxt;
         r_busy  <= (w_state_nxt != IDLE);
         r_done  <= (r_state == STOP) && w_end_slot;
         if (w_accept) begin
            r_rw    <= I_RW;
            r_addr  <= I_ADDR;
            r_wdata <= I_WDATA;
            r_nack  <= 1'b0;
         end
         if (w_tick && (r_q == Q2)) begin
            r_sample <= I_SDA_IN;
            if (r_state == RDATA) r_shift <= {r_shift[6:0], I_SDA_IN};
         end
         if (w_end_slot) begin
            if ((r_state == ADDR_ACK) && r_sample) r_nack  <= 1'b1;
            if (r_state == WDATA_ACK)              r_nack  <= r_sample;
            if ((r_state == RDATA) && (r_bit == 3'd7)) r_rdata <= r_shift;
         end
      end
   end

   assign O_SDA_T = r_sda_t;
   assign O_SCL_T = r_scl_t;
   assign O_BUSY  = r_busy;
   assign O_DONE  = r_done;
   assign O_NACK  = r_nack;
   assign O_RDATA = r_rdata;

endmodule

// File: tb/tb_i2c_master.sv
// Scoreboard bench for i2c_master with an open-drain slave model on the bus.
module tb_i2c_master;

   localparam int CLK_DIV = 4;

   typedef struct {
      logic       nack;
      logic [7:0] rdata;
      int         lat;
      int         nbytes;
      logic [7:0] b0;
      logic [7:0] b1;
      logic       ack9;
      int         rises;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       rw = 1'b0;
   logic [6:0] addr = 7'd0;
   logic [7:0] wdata = 8'd0;
   logic       sda_t, scl_t, busy, done, nack;
   logic [7:0] rdata;

   logic       slv_sda = 1'b1;
   logic       slv_scl = 1'b1;
   logic       slv_present = 1'b1;
   logic [7:0] slv_rdata = 8'h00;
   logic       w_sda_bus, w_scl_bus;

   assign w_sda_bus = sda_t & slv_sda;
   assign w_scl_bus = scl_t & slv_scl;

   int         n_checks = 0;
   int         n_fail = 0;
   int         cyc = 0;
   exp_t       exp_q[$];
   logic [7:0] obs_bytes[$];
   logic       obs_ack[$];
   int         obs_rises = 0;

   i2c_master #(.CLK_DIV(CLK_DIV)) dut (
      .I_CLK    (clk),
      .I_RESET  (rst),
      .I_START  (start),
      .I_RW     (rw),
      .I_ADDR   (addr),
      .I_WDATA  (wdata),
      .I_SDA_IN (w_sda_bus),
      .I_SCL_IN (w_scl_bus),
      .O_SDA_T  (sda_t),
      .O_SCL_T  (scl_t),
      .O_BUSY   (busy),
      .O_DONE   (done),
      .O_NACK   (nack),
      .O_RDATA  (rdata)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Slave model: decodes START/STOP, records bytes and 9th bits, ACKs address 0x50 when present.
   initial begin
      logic       scl, sda, p_scl, p_sda, s_active, s_rw, s_acked, s_reading;
      logic [7:0] s_shift;
      int         s_cnt, s_idx;
      p_scl = 1'b1; p_sda = 1'b1; s_active = 1'b0; s_rw = 1'b0;
      s_acked = 1'b0; s_reading = 1'b0; s_shift = 8'd0; s_cnt = 0; s_idx = 0;
      forever begin
         @(negedge clk);
         scl = w_scl_bus;
         sda = w_sda_bus;
         if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b1 && sda === 1'b0) begin
            s_active = 1'b1; s_cnt = 0; s_idx = 0; s_reading = 1'b0; s_acked = 1'b0;
            slv_sda = 1'b1;
            obs_bytes.delete(); obs_ack.delete(); obs_rises = 0;
         end else if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b0 && sda === 1'b1) begin
            s_active = 1'b0;
            slv_sda = 1'b1;
         end else if (s_active && p_scl === 1'b0 && scl === 1'b1) begin
            obs_rises++;
            if (s_cnt < 8) begin
               s_shift = {s_shift[6:0], sda};
               s_cnt++;
               if (s_cnt == 8) obs_bytes.push_back(s_shift);
            end else begin
               obs_ack.push_back(sda);
               s_cnt = 9;
            end
         end else if (s_active && p_scl === 1'b1 && scl === 1'b0) begin
            if (s_cnt == 8) begin
               if (s_idx == 0) begin
                  s_rw = s_shift[0];
                  s_acked = slv_present && (s_shift[7:1] == 7'h50);
                  slv_sda = !s_acked;
               end else begin
                  slv_sda = s_reading ? 1'b1 : 1'b0;
               end
            end else if (s_cnt == 9) begin
               slv_sda = 1'b1;
               s_cnt = 0;
               s_idx++;
               s_reading = (s_idx == 1) && s_rw && s_acked;
               if (s_reading) slv_sda = slv_rdata[7];
            end else if (s_reading && s_cnt >= 1 && s_cnt <= 7) begin
               slv_sda = slv_rdata[7 - s_cnt];
            end
         end
         p_scl = scl;
         p_sda = sda;
      end
   end

   // Monitor: measures BUSY-to-DONE latency and checks each completed transaction.
   initial begin
      logic p_busy;
      int   t_rise;
      exp_t e;
      p_busy = 1'b0;
      t_rise = 0;
      forever begin
         @(negedge clk);
         if (busy === 1'b1 && p_busy !== 1'b1) t_rise = cyc;
         p_busy = busy;
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("busy_at_done", busy, 32'd0);
               check("nack", nack, e.nack);
               check("rdata", rdata, e.rdata);
               check("latency", cyc - t_rise, e.lat);
               check("nbytes", obs_bytes.size(), e.nbytes);
               check("n_ackbits", obs_ack.size(), e.nbytes);
               check("scl_rises", obs_rises, e.rises);
               if (obs_bytes.size() > 0) check("byte0", obs_bytes[0], e.b0);
               if (obs_bytes.size() > 1 && e.nbytes > 1) check("byte1", obs_bytes[1], e.b1);
               if (obs_ack.size() > 0) check("ack9", obs_ack[obs_ack.size()-1], e.ack9);
            end
         end
      end
   end

   task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      start = 1'b1; rw = r; addr = a; wdata = d;
      @(posedge clk); #1;
      start = 1'b0; rw = ~r; addr = 7'h2B; wdata = ~d;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 3000) check(name, 32'd0, 32'd1);
   endtask

   task automatic push(input logic nk, input logic [7:0] rd, input int lat, input int nb,
                       input logic [7:0] b0, input logic [7:0] b1, input logic a9, input int rs);
      exp_t e;
      e.nack = nk; e.rdata = rd; e.lat = lat; e.nbytes = nb;
      e.b0 = b0; e.b1 = b1; e.ack9 = a9; e.rises = rs;
      exp_q.push_back(e);
   endtask

   initial begin
      int n, seen;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_sda_t", sda_t, 32'd1);
      check("rst_scl_t", scl_t, 32'd1);
      check("rst_busy", busy, 32'd0);
      check("rst_done", done, 32'd0);
      check("rst_nack", nack, 32'd0);
      check("rst_rdata", rdata, 32'd0);

      // write 0x50 <- 0xA5, slave ACKs
      push(1'b0, 8'h00, 80*CLK_DIV, 2, 8'hA0, 8'hA5, 1'b0, 19);
      issue(1'b0, 7'h50, 8'hA5);
      wait_done("timeout_write");
      repeat (10) @(posedge clk);

      // read 0x50, slave returns 0x3C, master NACKs
      slv_rdata = 8'h3C;
      push(1'b0, 8'h3C, 80*CLK_DIV, 2, 8'hA1, 8'h3C, 1'b1, 19);
      issue(1'b1, 7'h50, 8'h00);
      wait_done("timeout_read");
      repeat (10) @(posedge clk);

      // no slave: address NACK, STOP right after ADDR_ACK
      slv_present = 1'b0;
      push(1'b1, 8'h3C, 44*CLK_DIV, 1, 8'hA0, 8'h00, 1'b1, 10);
      issue(1'b0, 7'h50, 8'h77);
      wait_done("timeout_nack");
      repeat (10) @(posedge clk);
      slv_present = 1'b1;

      // slave stretches SCL 50 cycles in the first ADDR bit
      push(1'b0, 8'h3C, 80*CLK_DIV + 50, 2, 8'hA0, 8'h5A, 1'b0, 19);
      issue(1'b0, 7'h50, 8'h5A);
      check("nack_clr_on_accept", nack, 32'd0);
      n = 0;
      while (scl_t !== 1'b0 && n < 200) begin @(posedge clk); #1; n++; end
      while (scl_t !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
      if (n >= 200) check("timeout_stretch_edge", 32'd0, 32'd1);
      slv_scl = 1'b0;
      repeat (50) @(posedge clk);
      #1 slv_scl = 1'b1;
      wait_done("timeout_stretch");
      repeat (10) @(posedge clk);

      // I_START while busy is ignored, including during the final STOP cycle
      push(1'b0, 8'h3C, 80*CLK_DIV, 2, 8'hA0, 8'h11, 1'b0, 19);
      issue(1'b0, 7'h50, 8'h11);
      repeat (40) @(posedge clk);
      #1 start = 1'b1; rw = 1'b1; addr = 7'h22; wdata = 8'hFF;
      repeat (10) @(posedge clk);
      #1 start = 1'b0;
      repeat (100) @(posedge clk);
      #1 start = 1'b1;
      wait_done("timeout_busy_ignore");
      start = 1'b0;
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (busy !== 1'b0) seen = 1;
      end
      check("start_in_last_busy_ignored", seen, 32'd0);

      // reset mid-ADDR releases both lines at once
      issue(1'b0, 7'h50, 8'hA5);
      repeat (30) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_sda_t", sda_t, 32'd1);
      check("midrst_scl_t", scl_t, 32'd1);
      check("midrst_busy", busy, 32'd0);
      check("midrst_done", done, 32'd0);
      check("midrst_nack", nack, 32'd0);
      check("midrst_rdata", rdata, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      seen = 0;
      repeat (400) begin
         @(posedge clk); #1;
         if (busy !== 1'b0) seen = 1;
      end
      check("no_activity_after_reset", seen, 32'd0);
      check("pending_expected", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
